// File: rtl/fifo_sync_flags.sv
// -----------------------------------------------------------------------------
// fifo_sync_flags
//   Single-clock FIFO with an occupancy count, programmable almost-full and
//   almost-empty thresholds, one-cycle overflow/underflow error pulses and an
//   optional first-word-fall-through read port.
//
// Parameters
//   DATA_WIDTH  word width in bits
//   MEM_DEPTH   number of entries (power of 2, >= 4)
//   FWFT        0 = registered read (dout valid the cycle after rd_en)
//               1 = first-word-fall-through (dout shows head while not empty)
//   AF_THRESH   almost_full  when count >= AF_THRESH (1..MEM_DEPTH)
//   AE_THRESH   almost_empty when count <= AE_THRESH (0..MEM_DEPTH-1)
//
// Ports
//   clk, rst      single rising-edge clock, synchronous active-high reset
//   wr_en, din    write request and data
//   rd_en         read request (pop of the head word in FWFT mode)
//   dout          read data
//   full, empty, almost_full, almost_empty   flags decoded from count
//   count         registered occupancy, 0..MEM_DEPTH
//   overflow      one-cycle pulse after a write was rejected (FIFO full)
//   underflow     one-cycle pulse after a read was rejected (FIFO empty)
//
// Handshake: a write is accepted on a rising edge where wr_en=1 and full=0;
// a read is accepted on a rising edge where rd_en=1 and empty=0. A request
// that meets a full/empty FIFO is dropped and reported by the matching error
// pulse on the next cycle; it never moves pointers, count or data. Both
// requests in the same cycle are evaluated against the pre-edge count, so a
// full FIFO still accepts the read and an empty one still accepts the write.
// -----------------------------------------------------------------------------
module fifo_sync_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = MEM_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(MEM_DEPTH):0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(MEM_DEPTH);
    localparam logic [CW-1:0] CNT_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_AE    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags come only from the registered count, never from the requests.
    assign full         = (count_q == CNT_DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Requests are ignored entirely while rst is high.
    assign wr_ok = !rst && wr_en && !full;
    assign rd_ok = !rst && rd_en && !empty;

    // Storage has no reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;   // wraps naturally, depth is 2^AW
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_ok && !rd_ok) begin
                count_q <= count_q + CNT_ONE;
            end else if (rd_ok && !wr_ok) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // hold_q remembers the head word last shown so dout stays put
            // once the FIFO drains.
            logic [DATA_WIDTH-1:0] hold_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_q <= '0;
                end else if (!empty) begin
                    hold_q <= mem[rd_ptr];
                end
            end

            assign dout = empty ? hold_q : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_flags
//   Drives one stimulus stream into two FIFOs: a standard-read instance with
//   default thresholds (14/2) and a first-word-fall-through instance with the
//   extreme thresholds (16/0). A queue-based model predicts every output each
//   cycle.
// -----------------------------------------------------------------------------
module tb_fifo_sync_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int AF0   = DEPTH - 2;
    localparam int AE0   = 2;
    localparam int AF1   = DEPTH;
    localparam int AE1   = 0;

    // ---------------- clock / reset / DUT signals ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;

    logic [DW-1:0] dout_s, dout_f;
    logic          full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
    logic          full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [CW-1:0] count_s, count_f;

    always #5 clk = ~clk;

    fifo_sync_flags #(
        .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .FWFT(0),
        .AF_THRESH(AF0), .AE_THRESH(AE0)
    ) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
        .overflow(ovf_s), .underflow(udf_s)
    );

    fifo_sync_flags #(
        .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .FWFT(1),
        .AF_THRESH(AF1), .AE_THRESH(AE1)
    ) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ovf_f), .underflow(udf_f)
    );

    // ---------------- scoreboard / reference model ----------------
    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;

    logic [DW-1:0] exp_q[$];     // words currently held, head at index 0
    logic [DW-1:0] m_dout_std;   // last word popped (registered-read port)
    logic [DW-1:0] m_shown;      // last head word shown (FWFT port)
    logic          m_ovf;
    logic          m_udf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the FIFO described as queue operations.
    task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r, input logic rs);
        int  sz;
        logic w_acc, r_acc;
        sz = exp_q.size();
        if (sz > 0) m_shown = exp_q[0];
        if (rs) begin
            exp_q.delete();
            m_dout_std = '0;
            m_shown    = '0;
            m_ovf      = 1'b0;
            m_udf      = 1'b0;
        end else begin
            w_acc = w && (sz < DEPTH);
            r_acc = r && (sz > 0);
            m_ovf = w && !w_acc;
            m_udf = r && !r_acc;
            if (r_acc) m_dout_std = exp_q.pop_front();
            if (w_acc) exp_q.push_back(d);
        end
    endtask

    task automatic compare_all();
        int sz;
        logic [DW-1:0] exp_f;
        sz    = exp_q.size();
        exp_f = (sz > 0) ? exp_q[0] : m_shown;
        check("count_std",  32'(count_s), 32'(sz));
        check("count_fwft", 32'(count_f), 32'(sz));
        check("full_std",   32'(full_s),  32'(sz == DEPTH));
        check("empty_std",  32'(empty_s), 32'(sz == 0));
        check("af_std",     32'(af_s),    32'(sz >= AF0));
        check("ae_std",     32'(ae_s),    32'(sz <= AE0));
        check("full_fwft",  32'(full_f),  32'(sz == DEPTH));
        check("empty_fwft", 32'(empty_f), 32'(sz == 0));
        check("af_fwft",    32'(af_f),    32'(sz >= AF1));
        check("ae_fwft",    32'(ae_f),    32'(sz <= AE1));
        check("ovf_std",    32'(ovf_s),   32'(m_ovf));
        check("udf_std",    32'(udf_s),   32'(m_udf));
        check("ovf_fwft",   32'(ovf_f),   32'(m_ovf));
        check("udf_fwft",   32'(udf_f),   32'(m_udf));
        check("dout_std",   32'(dout_s),  32'(m_dout_std));
        check("dout_fwft",  32'(dout_f),  32'(exp_f));
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic rs);
        rst   = rs;
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        model_edge(w, d, r, rs);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        exp_q.delete();
        m_dout_std = '0;
        m_shown    = '0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
        rst = 1'b1; wr_en = 1'b0; din = '0; rd_en = 1'b0;

        // Reset state
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        idle(1);

        // Fill 0x00..0x0F, check threshold crossings one word at a time
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        check("filled_count", 32'(count_s), 32'(DEPTH));

        // Overflow at full, then drain: 0xAA must never appear
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_pulse", 32'(ovf_s), 32'd1);
        idle(1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("drained_empty", 32'(empty_s), 32'd1);

        // Underflow on empty; simultaneous read+write at empty
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        check("fwft_head", 32'(dout_f), 32'h5A);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // Count 5, ten cycles of simultaneous read+write
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
        check("steady_count", 32'(count_s), 32'd5);

        // Simultaneous read+write at full
        while (exp_q.size() < DEPTH) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        idle(1);

        // Reset mid-operation at count 7 with wr_en held high
        cycle(1'b1, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        check("rst_count", 32'(count_s), 32'd0);
        idle(2);

        // Random traffic with biased write/read rates
        for (int ph = 0; ph < 4; ph++) begin
            int pw, pr;
            case (ph)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                2:       begin pw = 60; pr = 60; end
                default: begin pw = 95; pr = 95; end
            endcase
            for (int i = 0; i < 400; i++) begin
                cycle($urandom_range(0, 99) < pw,
                      DW'($urandom_range(0, 255)),
                      $urandom_range(0, 99) < pr,
                      $urandom_range(0, 299) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
